// File: rtl/result_serializer_pkg.sv
// Shared definitions for the result serializer: result word field offsets,
// frame length and the IDLE/SEND state encoding.
package result_serializer_pkg;

  localparam int SIGN_BIT        = 64;
  localparam int Q_MSB           = 63;
  localparam int Q_LSB           = 32;
  localparam int R_MSB           = 31;
  localparam int BYTES_PER_FRAME = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full and pop while
// empty are ignored so callers cannot corrupt the pointers.
module sync_fifo #(
  parameter int DATA_WIDTH       = 65,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [LOG_BUFFER_DEPTH-1:0] count
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Explicit wrap so non-power-of-two depths stay modulo BUFFER_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == LOG_BUFFER_DEPTH'(BUFFER_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Buffers divider results and emits each as an 8-byte frame on the chip bus,
// remainder LSB first, with a pull_out strobe on byte 0 and a one-cycle gap.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int DATA_WIDTH       = 65,
  parameter int BUFFER_DEPTH     = 4,
  parameter int LOG_BUFFER_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [7:0]            data_out_out,
  output logic                  pull_out,
  output logic                  sign_out
);

  state_t                      state;
  state_t                      state_nxt;
  logic [2:0]                  byte_cnt;
  logic [2:0]                  byte_cnt_nxt;
  logic [Q_MSB:0]              shreg;
  logic [Q_MSB:0]              shreg_nxt;
  logic                        sign_nxt;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [DATA_WIDTH-1:0]       fifo_head;
  logic [LOG_BUFFER_DEPTH-1:0] fifo_count;

  // Ready depends only on registered occupancy: no bypass when full.
  assign in_ready  = (fifo_count != LOG_BUFFER_DEPTH'(BUFFER_DEPTH));
  assign fifo_push = in_valid && !fifo_full;

  sync_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .BUFFER_DEPTH    (BUFFER_DEPTH),
    .LOG_BUFFER_DEPTH(LOG_BUFFER_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_data(in_data),
    .rd_data(fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    shreg_nxt    = shreg;
    sign_nxt     = sign_out;
    fifo_pop     = 1'b0;
    data_out_out = 8'h00;
    pull_out     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shreg_nxt    = fifo_head[Q_MSB:0];
          sign_nxt     = fifo_head[SIGN_BIT];
          byte_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        data_out_out = shreg[7:0];
        pull_out     = (byte_cnt == '0);
        shreg_nxt    = shreg >> 8;
        byte_cnt_nxt = byte_cnt + 1'b1;
        // Last byte returns to IDLE, which forces the one-cycle zero gap.
        if (byte_cnt == 3'(BYTES_PER_FRAME - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      sign_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      sign_out <= sign_nxt;
    end
  end

  // Shift register is pure data; the state gating keeps it off the bus.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_result_serializer.sv
// Randomised bench for result_serializer with a queue-based frame model
// and a few hand-computed frames.
module tb_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [64:0] in_data;
  logic        in_ready;
  logic [7:0]  data_out_out;
  logic        pull_out;
  logic        sign_out;

  int tests;
  int fails;

  result_serializer #(
    .DATA_WIDTH      (65),
    .BUFFER_DEPTH    (4),
    .LOG_BUFFER_DEPTH(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .data_out_out(data_out_out),
    .pull_out    (pull_out),
    .sign_out    (sign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO as a queue, the frame in flight as a word plus a byte index.
  logic [64:0] fq[$];
  logic [64:0] exp_frames[$];
  logic [64:0] m_cur;
  bit          m_busy;
  int          m_k;
  logic        m_sign;
  bit          m_acc;

  initial begin
    m_busy = 0; m_k = 0; m_sign = 0; m_cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fq.delete(); exp_frames.delete();
        m_busy = 0; m_k = 0; m_sign = 0;
      end else begin
        m_acc = in_valid && (fq.size() != 4);
        if (m_busy) begin
          if (m_k == 7) m_busy = 0;
          else m_k++;
        end else if (fq.size() > 0) begin
          m_cur = fq.pop_front();
          m_busy = 1; m_k = 0; m_sign = m_cur[64];
        end
        if (m_acc) begin
          fq.push_back(in_data);
          exp_frames.push_back(in_data);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("bus", data_out_out, m_busy ? 8'(m_cur[8*m_k +: 8]) : 8'h00);
      chk("pull", pull_out, m_busy && (m_k == 0));
      chk("sign", sign_out, m_sign);
      chk("ready", in_ready, fq.size() != 4);
    end
  end

  // Reassemble frames from the bus and compare with the accepted stream in order.
  logic [63:0] asm_w;
  logic        asm_s;
  int          nb;
  bit          cap;
  int          frames_seen;
  initial begin
    nb = 0; cap = 0; frames_seen = 0; asm_w = '0; asm_s = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; cap = 0;
      end else begin
        if (pull_out) begin cap = 1; nb = 0; end
        if (cap) begin
          asm_w[8*nb +: 8] = data_out_out;
          asm_s = sign_out;
          nb++;
          if (nb == 8) begin
            cap = 0;
            frames_seen++;
            if (exp_frames.size() == 0) chk("frame_unexpected", {asm_s, asm_w}, 65'h0);
            else chk("frame", {asm_s, asm_w}, exp_frames.pop_front());
          end
        end
      end
    end
  end

  // Hold in_valid with w until accepted; returns the index of the accepting edge.
  task automatic push(input logic [64:0] w, output int edge_idx);
    bit rdy;
    bit ok;
    ok = 0; edge_idx = -1;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        edge_idx = int'(($time - 5) / 10);
        ok = 1;
        break;
      end
    end
    #1;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  // seq lists the expected bus bytes in emission order, first byte in the top byte.
  task automatic frame_lit(input string tag, input logic [64:0] w, input logic [63:0] seq,
                           input logic sgn);
    int e;
    push(w, e);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_pre"}, {pull_out, data_out_out}, 9'h000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk({tag, "_byte"}, data_out_out, seq[63-8*k -: 8]);
      chk({tag, "_pull"}, pull_out, k == 0);
      chk({tag, "_sign"}, sign_out, sgn);
    end
    @(negedge clk);
    chk({tag, "_gap"}, {pull_out, data_out_out}, 9'h000);
  endtask

  initial begin
    int e[6];
    int pulls;
    int gap;
    int ed;
    logic [64:0] w;
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    chk("reset_bus", data_out_out, 8'h00);
    chk("reset_pull", pull_out, 1'b0);
    chk("reset_sign", sign_out, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    frame_lit("single", {1'b0, 32'h00000007, 32'h00000001}, 64'h01000000_07000000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    frame_lit("signed", {1'b1, 32'h80000003, 32'h80000002}, 64'h02000080_03000080, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Fill and stall with six distinct words under continuous valid.
    for (int i = 0; i < 6; i++) push({1'(i & 1), 32'hA000_0000 + 32'(i), 32'h0B00_0000 + 32'(i)}, e[i]);
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) chk("fill_consecutive", e[i] - e[0], i);
    chk("fill_sixth_after_stall", e[5] - e[0], 11);
    repeat (60) @(posedge clk);
    #1;

    // Reset during byte 3 of a frame.
    push({1'b1, 32'h12345678, 32'hDEADBEEF}, ed);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_byte3", data_out_out, 8'hDE);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_bus", data_out_out, 8'h00);
    chk("midreset_pull", pull_out, 1'b0);
    chk("midreset_sign", sign_out, 1'b0);
    chk("midreset_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulls = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pull_out) pulls++;
    end
    chk("post_reset_no_frame", pulls, 0);
    #1;

    // Random regression with random valid gaps.
    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 12);
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      w = {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
      push(w, ed);
    end
    in_valid = 1'b0;
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("all_frames_drained", exp_frames.size(), 0);
    chk("random_frames_seen", frames_seen >= 80 + 2 + 6, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream output stage of the byte-serial divider. Accepts completed divide results `{sign, quotient[31:0], remainder[31:0]}` from the divider core over a valid/ready handshake and buffers them in a small FIFO. It then emits each result on the 8-bit chip output bus as an 8-byte frame, marked by a one-cycle `pull_out` strobe.

## Interface
- `DATA_WIDTH`, 65: result word width, `{sign, quotient, remainder}`; bit 64 = sign mode, [63:32] = quotient, [31:0] = remainder.
- `BUFFER_DEPTH`, 4: number of FIFO entries.
- `LOG_BUFFER_DEPTH`, 3: occupancy counter width; holds 0..`BUFFER_DEPTH`.
- Clock and reset (fixed): one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  core result valid.
- `in_data`  in  `DATA_WIDTH`  result word.
- `in_ready`  out  1  FIFO can accept a word.
- `data_out_out`  out  8  serial result byte.
- `pull_out`  out  1  high only during byte 0 of a frame.
- `sign_out`  out  1  sign mode of the frame being or last emitted.

## Operation
- A word is accepted on an edge where `in_valid && in_ready`. It is written to the FIFO tail.
- `in_ready = (count != BUFFER_DEPTH)`. It is registered-state based and independent of `in_valid`.
- When full, `in_ready` is 0 even if a pop occurs in the same cycle. There is no full-bypass.
- Push and pop in the same cycle on a non-full FIFO leave `count` unchanged. Pointers wrap modulo `BUFFER_DEPTH`.
- The FSM has two states, IDLE and SEND.
- IDLE:
  - `data_out_out = 0` and `pull_out = 0`.
  - If the FIFO is non-empty: pop the head into a 64-bit shift register, set `sign_out <= head[64]`, set the byte counter to 0, and go to SEND.
  - An empty FIFO is not bypassed: a word written this edge is loaded no earlier than the next edge.
- SEND:
  - `data_out_out` = shift register [7:0].
  - On each edge, shift the register right by 8 and increment the byte counter.
  - When the counter reaches 7, go to IDLE instead.
- Byte order is k = 0..7: byte k = `{quotient, remainder}[8k+7:8k]`. This is remainder LSB first and quotient MSB last.
- `pull_out = 1` only while the counter is 0 in SEND.
- `sign_out` holds its value until the next load.
- The serializer does not interpret the result. Divide-by-zero results pass through unchanged.

## Timing
- Reset values: `data_out_out = 8'h00`, `pull_out = 0`, `sign_out = 0`, `in_ready = 1`. State is IDLE, FIFO is empty, all pointers and counters are 0.
- Latency: a word accepted at edge E into an empty, idle block is loaded at E+1. Byte 0 and `pull_out` are visible E+1 to E+2, and byte 7 is visible E+8 to E+9.
- Frame period is 9 cycles: 8 byte cycles plus 1 mandatory IDLE gap with a zero bus. Back-to-back frames have exactly one gap cycle.
- Sustained throughput is one result per 9 cycles. A continuous `in_valid` stream fills the FIFO and then is throttled by `in_ready`.
- Reset asserted mid-frame: outputs go to reset values immediately, the FIFO is flushed and the partial frame is discarded. After release, the first frame starts only from a new acceptance.

## Structure
- Shared package holds:
  - result field offsets: `SIGN_BIT = 64`, `Q_MSB = 63`, `Q_LSB = 32`, `R_MSB = 31`;
  - `BYTES_PER_FRAME = 8`;
  - the IDLE/SEND state encoding.
- One sub-module, `sync_fifo`. It is parameterised by `DATA_WIDTH`, `BUFFER_DEPTH` and `LOG_BUFFER_DEPTH`, and provides push, pop, empty, full and count, with an asynchronous active-low reset.
- The top level contains the FSM, byte counter, shift register and output registers.

## Test plan
- Single frame: push `{0, 32'h00000007, 32'h00000001}` -> bytes `01 00 00 00 07 00 00 00` on 8 consecutive cycles, `pull_out` only with `01`, `sign_out = 0`, bus 0 afterwards.
- Signed frame: push `{1, 32'h80000003, 32'h80000002}` -> `sign_out = 1` from byte 0, bytes `02 00 00 80 03 00 00 80`.
- Fill and stall: hold `in_valid` with 6 distinct words -> 5 accepted on 5 consecutive edges, `in_ready` low afterwards, sixth accepted only after the second frame's load edge, all 6 frames in order with 1-cycle gaps.
- Reset mid-frame: assert `rst_n = 0` during byte 3 -> bus 0, `pull_out = 0` immediately; after release, no frame until a new push.
- Latency check: push at edge E into an idle block -> `pull_out` high exactly between E+1 and E+2.
- Random regression: push 80 random words with random `in_valid` gaps -> reassembled `{q, r, sign}` matches the pushed stream in order.
